// File: rtl/stage4_mem_access.sv
// MEM stage: issues lw/sw over a req/ack data-memory port and registers the MEM/WB bundle (1-cycle latency when idle).
// Backpressure: STALL_MEM holds the upstream stages from the request cycle until the ACK cycle; a watchdog aborts hung accesses.
module stage4_mem_access #(
   parameter int N       = 32,
   parameter int TIMEOUT = 15
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic [N-1:0] ALURes_ExMem,
   input  logic [N-1:0] DataRs2_ExMem,
   input  logic [4:0]   AddRD_ExMem,
   input  logic         memWR_ExMem,
   input  logic         memRD_ExMem,
   input  logic         memToReg_ExMem,
   input  logic         regWR_ExMem,
   output logic         DMEM_REQ,
   output logic         DMEM_WE,
   output logic [N-3:0] DMEM_ADDR,
   output logic [N-1:0] DMEM_WDATA,
   input  logic [N-1:0] DMEM_RDATA,
   input  logic         DMEM_ACK,
   output logic [4:0]   AddRD_MemWb,
   output logic [N-1:0] ALURes_MemWb,
   output logic [N-1:0] MemData_MemWb,
   output logic         memToReg_MemWb,
   output logic         regWR_MemWb,
   output logic         STALL_MEM,
   output logic         ERR_MISALIGN,
   output logic         ERR_TIMEOUT
);

   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t         state, state_nxt;
   logic [WW-1:0]  wdog;
   logic           start, misalign, done, expire, is_mem, aligned;

   // control captured at request time; EX/MEM is free to change while we wait
   logic [4:0]     lat_addrd;
   logic [N-1:0]   lat_alu;
   logic           lat_rd, lat_m2r, lat_regwr;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      is_mem    = memRD_ExMem | memWR_ExMem;
      aligned   = (ALURes_ExMem[1:0] == 2'b00);
      start     = 1'b0;
      misalign  = 1'b0;
      done      = 1'b0;
      expire    = 1'b0;
      state_nxt = state;
      STALL_MEM = 1'b0;
      if (state == IDLE) begin
         start    = EN & is_mem & aligned;
         misalign = EN & is_mem & ~aligned;
         if (start) state_nxt = WAIT_ACK;
      end else begin
         done   = DMEM_ACK;
         expire = ~DMEM_ACK & (wdog == WW'(TIMEOUT - 1));
         if (done | expire) state_nxt = IDLE;
      end
      // the expiry cycle releases the pipeline so the aborted access is dropped, not replayed
      STALL_MEM = ~RST & (start | ((state == WAIT_ACK) & ~done & ~expire));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wdog           <= '0;
         DMEM_REQ       <= 1'b0;
         DMEM_WE        <= 1'b0;
         DMEM_ADDR      <= '0;
         DMEM_WDATA     <= '0;
         lat_addrd      <= '0;
         lat_alu        <= '0;
         lat_rd         <= 1'b0;
         lat_m2r        <= 1'b0;
         lat_regwr      <= 1'b0;
         AddRD_MemWb    <= '0;
         ALURes_MemWb   <= '0;
         MemData_MemWb  <= '0;
         memToReg_MemWb <= 1'b0;
         regWR_MemWb    <= 1'b0;
         ERR_MISALIGN   <= 1'b0;
         ERR_TIMEOUT    <= 1'b0;
      end else begin
         ERR_MISALIGN <= misalign;
         ERR_TIMEOUT  <= expire;
         if (state == IDLE) begin
            wdog <= '0;
            if (start) begin
               DMEM_REQ       <= 1'b1;
               DMEM_WE        <= memWR_ExMem & ~memRD_ExMem;
               DMEM_ADDR      <= ALURes_ExMem[N-1:2];
               DMEM_WDATA     <= DataRs2_ExMem;
               lat_addrd      <= AddRD_ExMem;
               lat_alu        <= ALURes_ExMem;
               lat_rd         <= memRD_ExMem;
               lat_m2r        <= memToReg_ExMem;
               lat_regwr      <= regWR_ExMem;
               AddRD_MemWb    <= '0;
               ALURes_MemWb   <= '0;
               MemData_MemWb  <= '0;
               memToReg_MemWb <= 1'b0;
               regWR_MemWb    <= 1'b0;
            end else if (EN) begin
               AddRD_MemWb    <= AddRD_ExMem;
               ALURes_MemWb   <= ALURes_ExMem;
               MemData_MemWb  <= '0;
               memToReg_MemWb <= memToReg_ExMem;
               regWR_MemWb    <= regWR_ExMem & ~misalign;
            end
         end else begin
            wdog <= wdog + 1'b1;
            if (done) begin
               DMEM_REQ       <= 1'b0;
               DMEM_WE        <= 1'b0;
               AddRD_MemWb    <= lat_addrd;
               ALURes_MemWb   <= lat_alu;
               MemData_MemWb  <= lat_rd ? DMEM_RDATA : '0;
               memToReg_MemWb <= lat_m2r;
               regWR_MemWb    <= lat_regwr & lat_rd;
            end else if (expire) begin
               DMEM_REQ       <= 1'b0;
               DMEM_WE        <= 1'b0;
               AddRD_MemWb    <= '0;
               ALURes_MemWb   <= '0;
               MemData_MemWb  <= '0;
               memToReg_MemWb <= 1'b0;
               regWR_MemWb    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stage4_mem_access.sv
// Random and directed instruction stream against a transaction-level model of the MEM stage.
module tb_stage4_mem_access;
   localparam int N  = 32;
   localparam int TO = 6;

   logic         CLK = 1'b0;
   logic         RST, EN;
   logic [N-1:0] ALURes_ExMem, DataRs2_ExMem;
   logic [4:0]   AddRD_ExMem;
   logic         memWR_ExMem, memRD_ExMem, memToReg_ExMem, regWR_ExMem;
   logic         DMEM_REQ, DMEM_WE;
   logic [N-3:0] DMEM_ADDR;
   logic [N-1:0] DMEM_WDATA, DMEM_RDATA;
   logic         DMEM_ACK;
   logic [4:0]   AddRD_MemWb;
   logic [N-1:0] ALURes_MemWb, MemData_MemWb;
   logic         memToReg_MemWb, regWR_MemWb, STALL_MEM, ERR_MISALIGN, ERR_TIMEOUT;

   always #5 CLK = ~CLK;

   stage4_mem_access #(.N(N), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .ALURes_ExMem(ALURes_ExMem), .DataRs2_ExMem(DataRs2_ExMem), .AddRD_ExMem(AddRD_ExMem),
      .memWR_ExMem(memWR_ExMem), .memRD_ExMem(memRD_ExMem),
      .memToReg_ExMem(memToReg_ExMem), .regWR_ExMem(regWR_ExMem),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
      .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
      .AddRD_MemWb(AddRD_MemWb), .ALURes_MemWb(ALURes_MemWb), .MemData_MemWb(MemData_MemWb),
      .memToReg_MemWb(memToReg_MemWb), .regWR_MemWb(regWR_MemWb),
      .STALL_MEM(STALL_MEM), .ERR_MISALIGN(ERR_MISALIGN), .ERR_TIMEOUT(ERR_TIMEOUT)
   );

   int checks = 0;
   int errors = 0;

   // expected MEM/WB register contents
   logic [4:0]  exp_ad;
   logic [31:0] exp_alu, exp_md;
   logic        exp_m2r, exp_rw;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_memwb(input string tag);
      check({tag, ".addrd"}, AddRD_MemWb, exp_ad);
      check({tag, ".alu"},   ALURes_MemWb, exp_alu);
      check({tag, ".mdata"}, MemData_MemWb, exp_md);
      check({tag, ".m2r"},   memToReg_MemWb, exp_m2r);
      check({tag, ".regwr"}, regWR_MemWb, exp_rw);
   endtask

   task automatic set_model(input logic [4:0] ad, input logic [31:0] alu, md, input logic m2r, rw);
      exp_ad = ad; exp_alu = alu; exp_md = md; exp_m2r = m2r; exp_rw = rw;
   endtask

   task automatic drive_garbage();
      EN             = 1'($urandom);
      memRD_ExMem    = 1'($urandom);
      memWR_ExMem    = 1'($urandom);
      ALURes_ExMem   = $urandom;
      DataRs2_ExMem  = $urandom;
      AddRD_ExMem    = 5'($urandom);
      memToReg_ExMem = 1'($urandom);
      regWR_ExMem    = 1'($urandom);
   endtask

   // One instruction through MEM. Entered and left at a falling edge.
   // d = ACK delay in cycles after REQ rises; d >= TO means the memory never answers.
   task automatic run_op(input string tag, input logic en, rd, wr, input logic [31:0] alu, rs2,
                         input logic [4:0] ad, input logic m2r, rw, input int d, input logic [31:0] rdata,
                         output int stalls, output int reqs);
      logic acc, mis, ack;
      stalls = 0;
      reqs   = 0;
      EN = en; memRD_ExMem = rd; memWR_ExMem = wr; ALURes_ExMem = alu; DataRs2_ExMem = rs2;
      AddRD_ExMem = ad; memToReg_ExMem = m2r; regWR_ExMem = rw;
      DMEM_ACK = 1'($urandom);
      DMEM_RDATA = $urandom;
      acc = en && (rd || wr) && (alu[1:0] == 2'b00);
      mis = en && (rd || wr) && (alu[1:0] != 2'b00);
      #1;
      check({tag, ".stall_issue"}, STALL_MEM, acc);
      stalls += int'(STALL_MEM);
      @(negedge CLK);
      if (!acc) begin
         if (en) set_model(ad, alu, 32'h0, m2r, rw && !mis);
         check_memwb(tag);
         check({tag, ".misalign"}, ERR_MISALIGN, mis);
         check({tag, ".timeout"}, ERR_TIMEOUT, 1'b0);
         check({tag, ".noreq"}, DMEM_REQ, 1'b0);
         return;
      end
      set_model(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_memwb({tag, ".bubble"});
      check({tag, ".we"}, DMEM_WE, wr && !rd);
      check({tag, ".addr"}, DMEM_ADDR, alu >> 2);
      check({tag, ".wdata"}, DMEM_WDATA, rs2);
      for (int k = 0; k < TO; k++) begin
         ack = (k == d);
         drive_garbage();
         DMEM_ACK   = ack;
         DMEM_RDATA = ack ? rdata : $urandom;
         #1;
         reqs += int'(DMEM_REQ);
         check({tag, ".req_hold"}, DMEM_REQ, 1'b1);
         check({tag, ".addr_hold"}, DMEM_ADDR, alu >> 2);
         if (ack) check({tag, ".stall_ack"}, STALL_MEM, 1'b0);
         else if (k < TO - 1) check({tag, ".stall_wait"}, STALL_MEM, 1'b1);
         stalls += int'(STALL_MEM);
         @(negedge CLK);
         if (ack) break;
      end
      DMEM_ACK = 1'b0;
      if (d < TO) set_model(ad, alu, rd ? rdata : 32'h0, m2r, rw && rd);
      check_memwb({tag, ".done"});
      check({tag, ".timeout"}, ERR_TIMEOUT, d >= TO);
      check({tag, ".misalign0"}, ERR_MISALIGN, 1'b0);
      check({tag, ".req_drop"}, DMEM_REQ, 1'b0);
   endtask

   initial begin
      int st, rq, d;
      logic [31:0] a;
      RST = 1'b1; DMEM_ACK = 1'b0; DMEM_RDATA = '0;
      drive_garbage();
      repeat (3) @(negedge CLK);
      set_model(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_memwb("reset");
      check("reset.req", DMEM_REQ, 1'b0);
      check("reset.we", DMEM_WE, 1'b0);
      check("reset.addr", DMEM_ADDR, 30'h0);
      check("reset.stall", STALL_MEM, 1'b0);
      check("reset.errs", {ERR_MISALIGN, ERR_TIMEOUT}, 2'b00);
      RST = 1'b0;

      run_op("add", 1, 0, 0, 32'h10, 32'h0, 5'd5, 0, 1, 0, 32'h0, st, rq);
      run_op("lw", 1, 1, 0, 32'h40, 32'h0, 5'd6, 1, 1, 3, 32'hDEADBEEF, st, rq);
      check("lw.stall_cycles", st, 4);
      check("lw.req_cycles", rq, 4);
      run_op("sw", 1, 0, 1, 32'h44, 32'h1234, 5'd7, 0, 1, 0, 32'h0, st, rq);
      check("sw.stall_cycles", st, 1);
      check("sw.req_cycles", rq, 1);
      run_op("lw_mis", 1, 1, 0, 32'h42, 32'h0, 5'd8, 1, 1, 0, 32'h0, st, rq);
      run_op("lw_hang", 1, 1, 0, 32'h80, 32'h0, 5'd9, 1, 1, 1000, 32'h0, st, rq);
      check("hang.req_cycles", rq, TO);
      run_op("lw_late", 1, 1, 0, 32'h84, 32'h0, 5'd10, 1, 1, TO - 1, 32'hCAFEF00D, st, rq);
      check("late.req_cycles", rq, TO);
      run_op("hold", 0, 0, 0, 32'h99, 32'h0, 5'd11, 1, 1, 0, 32'h0, st, rq);

      // reset while waiting for ACK; the ACK arriving afterwards must be ignored
      EN = 1; memRD_ExMem = 1; memWR_ExMem = 0; ALURes_ExMem = 32'h100; AddRD_ExMem = 5'd12;
      regWR_ExMem = 1; memToReg_ExMem = 1; DMEM_ACK = 0;
      @(negedge CLK);
      check("rst_mid.req_up", DMEM_REQ, 1'b1);
      RST = 1'b1;
      #1;
      check("rst_mid.stall_in_rst", STALL_MEM, 1'b0);
      @(negedge CLK);
      RST = 1'b0; EN = 0; DMEM_ACK = 1; DMEM_RDATA = 32'h5555AAAA;
      set_model(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_memwb("rst_mid");
      check("rst_mid.req", DMEM_REQ, 1'b0);
      @(negedge CLK);
      DMEM_ACK = 0;
      check_memwb("rst_mid.ack_ignored");
      check("rst_mid.req2", DMEM_REQ, 1'b0);

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         if ($urandom_range(3) != 0) a[1:0] = 2'b00;
         d = int'($urandom_range(TO + 1));
         run_op("rand", ($urandom_range(7) != 0), 1'($urandom), 1'($urandom), a, $urandom,
                5'($urandom), 1'($urandom), 1'($urandom), d, $urandom, st, rq);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
